// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its next-PC logic.
package fetch_sequencer_pkg;

    typedef logic [31:0] word_t;

    // Sequencer phases: fetch an instruction, execute it, stall on data memory, stop.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Instructions are word aligned, so the two low address bits are always dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_logic.sv
// Combinational next-PC selection: JR beats J/JAL beats a taken branch beats pc+4.
module next_pc_logic
    import fetch_sequencer_pkg::*;
(
    input  word_t       pc,
    input  logic        jrsig,
    input  word_t       jr_addr,
    input  logic        jump,
    input  word_t       jump_addr,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    output word_t       next_pc,
    output word_t       pc_plus4
);

    word_t br_target;
    word_t sel_pc;

    // Branch offset is a signed word count relative to the following instruction.
    always_comb begin
        pc_plus4  = pc + PC_STEP;
        br_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};
    end

    // Priority select, then force word alignment (misaligned JR targets lose their low bits).
    always_comb begin
        sel_pc = pc_plus4;
        if (jrsig) begin
            sel_pc = jr_addr;
        end else if (jump) begin
            sel_pc = jump_addr;
        end else if (branch_taken) begin
            sel_pc = br_target;
        end
        next_pc = align_word(sel_pc);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC and instruction register, runs the imem/dmem request
// handshakes and emits a one-cycle commit pulse that gates register-file writes.
//
// Handshake: a request (imemREN, dmemREN, dmemWEN) is a level held high for as
// long as the sequencer sits in the requesting state; the memory completes it by
// raising ihit/dhit for one cycle, and the transfer happens on that clock edge.
// ihit/dhit seen in any other state are ignored.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         ihit,
    input  word_t        iload,
    output logic         imemREN,
    output word_t        imemaddr,
    input  logic         dhit,
    input  logic         memread,
    input  logic         memwrite,
    output logic         dmemREN,
    output logic         dmemWEN,
    input  logic         halt_in,
    input  logic         jump,
    input  word_t        jump_addr,
    input  logic         jrsig,
    input  word_t        jr_addr,
    input  logic         branch_taken,
    input  logic [15:0]  branch_off,
    output word_t        instr,
    output word_t        pc,
    output word_t        pc_plus4,
    output logic         commit,
    output logic         halt,
    output fetch_state_t state_dbg
);

    fetch_state_t state_q;
    word_t        pc_q;
    word_t        instr_q;
    logic         halt_q;
    word_t        next_pc_d;
    word_t        pc_plus4_d;

    next_pc_logic u_next_pc (
        .pc           (pc_q),
        .jrsig        (jrsig),
        .jr_addr      (jr_addr),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .next_pc      (next_pc_d),
        .pc_plus4     (pc_plus4_d)
    );

    // Sequencer FSM; PC only moves on retirement, instr only on ihit in FETCH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ihit) begin
                        instr_q <= iload;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (halt_in) begin
                        halt_q  <= 1'b1;
                        state_q <= HALTED;
                    end else if (memread || memwrite) begin
                        state_q <= MEM;
                    end else begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                    end
                end
                MEM: begin
                    if (dhit) begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Requests and commit decode from the current state; reset kills them in the same cycle.
    always_comb begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        commit  = 1'b0;
        if (!RST) begin
            case (state_q)
                FETCH: begin
                    imemREN = 1'b1;
                end
                EXEC: begin
                    commit = !halt_in && !(memread || memwrite);
                end
                MEM: begin
                    dmemWEN = memwrite;
                    dmemREN = memread && !memwrite;
                    commit  = dhit;
                end
                default: begin
                    commit = 1'b0;
                end
            endcase
        end
    end

    assign imemaddr  = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_d;
    assign instr     = instr_q;
    assign halt      = halt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic         CLK;
    logic         RST;
    logic         ihit;
    word_t        iload;
    logic         imemREN;
    word_t        imemaddr;
    logic         dhit;
    logic         memread;
    logic         memwrite;
    logic         dmemREN;
    logic         dmemWEN;
    logic         halt_in;
    logic         jump;
    word_t        jump_addr;
    logic         jrsig;
    word_t        jr_addr;
    logic         branch_taken;
    logic [15:0]  branch_off;
    word_t        instr;
    word_t        pc;
    word_t        pc_plus4;
    logic         commit;
    logic         halt;
    fetch_state_t state_dbg;

    int vectors;
    int miscompares;

    fetch_sequencer #(.PC_INIT(32'h0000_0000)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .iload        (iload),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .dhit         (dhit),
        .memread      (memread),
        .memwrite     (memwrite),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .halt_in      (halt_in),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .jrsig        (jrsig),
        .jr_addr      (jr_addr),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .commit       (commit),
        .halt         (halt),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver: return all decoder / memory inputs to idle.
    task automatic clear_inputs();
        ihit         = 1'b0;
        iload        = '0;
        dhit         = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        halt_in      = 1'b0;
        jump         = 1'b0;
        jump_addr    = '0;
        jrsig        = 1'b0;
        jr_addr      = '0;
        branch_taken = 1'b0;
        branch_off   = '0;
    endtask

    // Driver: next falling edge, idle inputs, present an instruction with ihit.
    task automatic drive_fetch(input word_t word);
        @(negedge CLK);
        clear_inputs();
        iload = word;
        ihit  = 1'b1;
    endtask

    // Driver: next falling edge, idle inputs (EXEC cycle inputs set by caller).
    task automatic next_cycle();
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        clear_inputs();
        RST = 1'b1;
        ihit = 1'b1;
        #1;
        vectors++;
        if ({imemREN, dmemREN, dmemWEN, commit} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs_forced got=%b exp=0000", {imemREN, dmemREN, dmemWEN, commit});
        end
        @(negedge CLK);
        RST = 1'b0;
        ihit = 1'b0;
        #1;
        vectors++;
        if (pc !== 32'h0 || instr !== 32'h0 || halt !== 1'b0 || state_dbg !== FETCH) begin
            miscompares++;
            $display("FAIL reset_state got pc=%h instr=%h halt=%b st=%0d exp pc=0 instr=0 halt=0 st=0",
                     pc, instr, halt, state_dbg);
        end
    endtask

    task automatic test_addu();
        // Cycle 1: FETCH with same-cycle ihit.
        iload = 32'h0022_1821;
        ihit  = 1'b1;
        #1;
        vectors++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0 || commit !== 1'b0) begin
            miscompares++;
            $display("FAIL addu_fetch got ren=%b addr=%h commit=%b exp 1/0/0", imemREN, imemaddr, commit);
        end
        // Cycle 2: EXEC, commit pulses.
        next_cycle();
        ihit = 1'b1;
        #1;
        vectors++;
        if (commit !== 1'b1 || instr !== 32'h0022_1821 || pc !== 32'h0 || pc_plus4 !== 32'h4 || imemREN !== 1'b0) begin
            miscompares++;
            $display("FAIL addu_exec got commit=%b instr=%h pc=%h pc4=%h ren=%b exp 1/00221821/0/4/0",
                     commit, instr, pc, pc_plus4, imemREN);
        end
        // Cycle 3: back in FETCH at pc=4.
        next_cycle();
        #1;
        vectors++;
        if (pc !== 32'h4 || imemaddr !== 32'h4 || imemREN !== 1'b1 || commit !== 1'b0) begin
            miscompares++;
            $display("FAIL addu_next got pc=%h addr=%h ren=%b commit=%b exp 4/4/1/0", pc, imemaddr, imemREN, commit);
        end
    endtask

    task automatic test_lw_stall();
        int ren_cycles;
        int commits;
        ren_cycles = 0;
        commits    = 0;
        iload = 32'h8c22_0000;
        ihit  = 1'b1;
        // EXEC: load decoded, no commit, no data request yet.
        next_cycle();
        memread = 1'b1;
        #1;
        vectors++;
        if (commit !== 1'b0 || dmemREN !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_exec got commit=%b dren=%b exp 0/0", commit, dmemREN);
        end
        // MEM: three wait cycles, then dhit.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            memread = 1'b1;
            dhit    = (i == 3);
            #1;
            if (dmemREN === 1'b1) ren_cycles++;
            if (commit === 1'b1) commits++;
            vectors++;
            if (commit !== (i == 3)) begin
                miscompares++;
                $display("FAIL lw_commit_timing cycle=%0d got=%b exp=%b", i, commit, (i == 3));
            end
        end
        next_cycle();
        #1;
        if (dmemREN === 1'b1) ren_cycles++;
        vectors++;
        if (ren_cycles !== 4 || commits !== 1) begin
            miscompares++;
            $display("FAIL lw_counts got ren_cycles=%0d commits=%0d exp 4/1", ren_cycles, commits);
        end
        vectors++;
        if (pc !== 32'h8 || imemREN !== 1'b1 || dmemREN !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_after got pc=%h ren=%b dren=%b exp 8/1/0", pc, imemREN, dmemREN);
        end
    endtask

    task automatic test_branch();
        // J to 0x40 from pc=8.
        drive_fetch(32'h0800_0010);
        next_cycle();
        jump      = 1'b1;
        jump_addr = 32'h0000_0040;
        #1;
        vectors++;
        if (commit !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_commit got=%b exp=1", commit);
        end
        // BEQ at 0x40 with offset -1 word: target 0x44 - 4 = 0x40.
        drive_fetch(32'h1000_ffff);
        #1;
        vectors++;
        if (imemaddr !== 32'h40) begin
            miscompares++;
            $display("FAIL jump_target got=%h exp=00000040", imemaddr);
        end
        next_cycle();
        branch_taken = 1'b1;
        branch_off   = 16'hFFFF;
        #1;
        vectors++;
        if (pc_plus4 !== 32'h44 || commit !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_exec got pc4=%h commit=%b exp 44/1", pc_plus4, commit);
        end
        next_cycle();
        #1;
        vectors++;
        if (pc !== 32'h40) begin
            miscompares++;
            $display("FAIL beq_target got=%h exp=00000040", pc);
        end
    endtask

    task automatic test_wrap();
        drive_fetch(32'h0800_0000);
        next_cycle();
        jump      = 1'b1;
        jump_addr = 32'hFFFF_FFFC;
        drive_fetch(32'h0000_0000);
        next_cycle();
        #1;
        vectors++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || commit !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_exec got pc=%h pc4=%h commit=%b exp fffffffc/0/1", pc, pc_plus4, commit);
        end
        next_cycle();
        #1;
        vectors++;
        if (pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_pc got=%h exp=00000000", pc);
        end
    endtask

    task automatic test_jr_priority();
        drive_fetch(32'h03e0_0008);
        next_cycle();
        jrsig        = 1'b1;
        jr_addr      = 32'h0000_0103;
        jump         = 1'b1;
        jump_addr    = 32'h0000_0200;
        branch_taken = 1'b1;
        branch_off   = 16'h0010;
        next_cycle();
        #1;
        vectors++;
        if (pc !== 32'h100) begin
            miscompares++;
            $display("FAIL jr_priority got=%h exp=00000100", pc);
        end
    endtask

    task automatic test_halt();
        drive_fetch(32'hFFFF_FFFF);
        next_cycle();
        halt_in = 1'b1;
        memread = 1'b1;
        #1;
        vectors++;
        if (commit !== 1'b0 || dmemREN !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_exec got commit=%b dren=%b exp 0/0", commit, dmemREN);
        end
        // Stay halted despite hits and decoder activity.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ihit     = 1'b1;
            dhit     = 1'b1;
            memwrite = 1'b1;
            #1;
            vectors++;
            if (halt !== 1'b1 || imemREN !== 1'b0 || commit !== 1'b0 || dmemWEN !== 1'b0 || pc !== 32'h100 || state_dbg !== HALTED) begin
                miscompares++;
                $display("FAIL halt_hold cycle=%0d got halt=%b ren=%b commit=%b dwen=%b pc=%h exp 1/0/0/0/100",
                         i, halt, imemREN, commit, dmemWEN, pc);
            end
        end
        test_reset();
        #1;
        vectors++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
            miscompares++;
            $display("FAIL halt_reset_fetch got ren=%b addr=%h exp 1/0", imemREN, imemaddr);
        end
    endtask

    task automatic test_sw_reset();
        iload = 32'hac22_0000;
        ihit  = 1'b1;
        next_cycle();
        memwrite = 1'b1;
        // MEM: load and store both flagged, write wins.
        next_cycle();
        memwrite = 1'b1;
        memread  = 1'b1;
        #1;
        vectors++;
        if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || commit !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_mem got dwen=%b dren=%b commit=%b exp 1/0/0", dmemWEN, dmemREN, commit);
        end
        // Reset in the middle of the stall.
        next_cycle();
        memwrite = 1'b1;
        RST      = 1'b1;
        #1;
        vectors++;
        if (dmemWEN !== 1'b0 || commit !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_reset_same_cycle got dwen=%b commit=%b exp 0/0", dmemWEN, commit);
        end
        next_cycle();
        RST = 1'b0;
        #1;
        vectors++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0 || dmemWEN !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_reset_restart got ren=%b addr=%h dwen=%b exp 1/0/0", imemREN, imemaddr, dmemWEN);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b1;
        clear_inputs();
        test_reset();
        test_addu();
        test_lw_stall();
        test_branch();
        test_wrap();
        test_jr_priority();
        test_halt();
        test_sw_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream neighbour of the single-cycle decoder. Owns the program counter and the instruction register, and runs the instruction/data memory request handshakes.
- Presents a stable instruction word and PC to the decoder.
- Stalls on data accesses. Issues a one-cycle commit pulse that gates register-file writes.
- Latches halt, which is sticky until reset.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory has returned iload this cycle.
- iload  in  32  instruction word from instruction memory.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction fetch address; equals pc.
- dhit  in  1  data memory access complete this cycle.
- memread  in  1  decoder: current instruction is a load.
- memwrite  in  1  decoder: current instruction is a store.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- halt_in  in  1  decoder: current instruction is HALT.
- jump  in  1  decoder: J/JAL.
- jump_addr  in  32  decoder jump target.
- jrsig  in  1  decoder: JR.
- jr_addr  in  32  register value for JR.
- branch_taken  in  1  branch condition true (beq&zero | bne&!zero), from datapath.
- branch_off  in  16  branch immediate, instr[15:0].
- instr  out  32  registered instruction word to decoder.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, used for JAL link.
- commit  out  1  one-cycle pulse: instruction retires; enables register-file write.
- halt  out  1  sticky halt flag.

Behaviour:
- States: FETCH, EXEC, MEM, HALTED.
- Reset values: state=FETCH, pc=PC_INIT, instr=0, halt=0.
- While RST is high, imemREN, dmemREN, dmemWEN and commit are forced to 0 in that same cycle.
- FETCH:
  - imemREN=1, imemaddr=pc.
  - On ihit: instr<=iload; next state EXEC.
  - ihit in the same cycle as entry to FETCH is accepted.
- EXEC: instr is stable; the decoder evaluates combinationally. Priority order:
  - halt_in: halt<=1; next state HALTED; no commit; pc unchanged.
  - Else memread|memwrite: next state MEM; no commit.
  - Else: commit=1; pc<=next_pc; next state FETCH.
- MEM:
  - dmemWEN=memwrite.
  - dmemREN=memread & !memwrite; write wins if both are asserted.
  - Requests are held until dhit.
  - On dhit: commit=1; pc<=next_pc; next state FETCH. Requests drop in the following cycle because the state changes.
- HALTED: all requests 0, commit 0; the state is held until RST.
- next_pc priority is jrsig > jump > branch_taken > pc+4:
  - Branch target = pc+4 + ({{14{branch_off[15]}}, branch_off, 2'b00}).
  - All arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - next_pc[1:0] is forced to 2'b00, so misaligned jr_addr low bits are discarded.
- Latency:
  - Non-memory instruction: minimum 2 cycles (FETCH with same-cycle ihit, then EXEC).
  - Load/store: minimum 3 cycles.
  - Each ihit/dhit wait cycle adds 1.
- Ignored inputs: ihit outside FETCH; dhit outside MEM; decoder inputs outside EXEC/MEM.
- RST asserted mid-MEM or mid-FETCH: requests drop in that cycle; the state machine restarts from PC_INIT on the next cycle.
- instr and pc are never altered except on ihit and on commit respectively.

Decomposition:
- cpu_types_pkg additions:
  - fetch_state_t enum {FETCH, EXEC, MEM, HALTED}.
  - word_t (32-bit) reuse.
  - PC_STEP = 32'd4.
- One combinational sub-module, next_pc_logic: takes pc, jrsig, jr_addr, jump, jump_addr, branch_taken, branch_off; outputs next_pc and pc_plus4.

Test Plan:
- Reset, then iload=ADDU with ihit held 1: imemaddr=0 in cycle 1, commit pulses in cycle 2, pc=4 in cycle 3.
- LW with ihit=1 and dhit delayed 3 cycles: dmemREN high for exactly 4 cycles, single commit on the dhit cycle, pc advances by 4.
- BEQ at pc=0x40, branch_off=16'hFFFF, branch_taken=1: pc becomes 0x40.
- JR with jr_addr=0x103, and jump=1 with jump_addr=0x200 both asserted: pc becomes 0x100 (jr wins, low bits cleared).
- HALT (halt_in=1) in EXEC: halt=1, no commit, no further imemREN; pc frozen; reset restores pc=PC_INIT and halt=0.
- RST asserted in the middle of a SW stall: dmemWEN=0 in the same cycle; next cycle imemREN=1 with imemaddr=PC_INIT.
